// File: rtl/ss_scroll_ctrl.sv
// Scrolling message controller for the 8-digit seven-segment driver: queues hex
// nibbles in a FIFO and shifts them into the display right-to-left on each scroll tick.
module ss_scroll_ctrl #(
   parameter int DEPTH      = 16,
   parameter int SCROLL_DIV = 50000000,
   parameter int CNT_W      = 26
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_valid,
   input  logic [3:0]               wr_data,
   output logic                     wr_ready,
   input  logic                     show,
   output logic [3:0]               digit7,
   output logic [3:0]               digit6,
   output logic [3:0]               digit5,
   output logic [3:0]               digit4,
   output logic [3:0]               digit3,
   output logic [3:0]               digit2,
   output logic [3:0]               digit1,
   output logic [3:0]               digit0,
   output logic [7:0]               mask,
   output logic                     busy,
   output logic                     done,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0]    FULL_LVL = LW'(DEPTH);
   localparam logic [LW-1:0]    ONE_LVL  = LW'(1);
   localparam logic [AW-1:0]    ONE_PTR  = AW'(1);
   localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
   localparam logic [CNT_W-1:0] TICK_CNT = CNT_W'(SCROLL_DIV - 1);

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      SCROLL = 1'b1
   } state_t;

   state_t          state_r;
   logic [3:0]      mem_r [DEPTH];
   logic [AW-1:0]   wr_ptr_r;
   logic [AW-1:0]   rd_ptr_r;
   logic [LW-1:0]   level_r;
   logic [CNT_W-1:0] cnt_r;
   logic [7:0][3:0] digit_r;
   logic [7:0]      mask_r;
   logic            busy_r;
   logic            done_r;

   logic            have_s;
   logic            push_s;
   logic            pop_s;
   logic            tick_s;
   logic            start_s;

   assign wr_ready = (level_r != FULL_LVL);

   // Handshake, tick and start qualifiers for the current cycle.
   always_comb begin
      have_s  = (level_r != {LW{1'b0}});
      push_s  = wr_valid & wr_ready;
      tick_s  = 1'b0;
      start_s = 1'b0;
      if (state_r == SCROLL) begin
         tick_s = (cnt_r == TICK_CNT);
      end else begin
         start_s = show & have_s;
      end
      pop_s = tick_s & have_s;
   end

   // FIFO storage; contents are invalidated by the pointer reset, not cleared.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         level_r  <= {LW{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + ONE_PTR;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + ONE_PTR;
         end
         case ({push_s, pop_s})
            2'b10:   level_r <= level_r + ONE_LVL;
            2'b01:   level_r <= level_r - ONE_LVL;
            default: level_r <= level_r;
         endcase
      end
   end

   // Scroll FSM with tick counter and registered display outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
         cnt_r   <= {CNT_W{1'b0}};
         digit_r <= 32'h0000_0000;
         mask_r  <= 8'h00;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (start_s) begin
                  digit_r <= 32'h0000_0000;
                  mask_r  <= 8'h00;
                  cnt_r   <= {CNT_W{1'b0}};
                  busy_r  <= 1'b1;
                  state_r <= SCROLL;
               end else begin
                  state_r <= IDLE;
               end
            end
            SCROLL: begin
               if (tick_s) begin
                  cnt_r <= {CNT_W{1'b0}};
                  if (have_s) begin
                     digit_r <= {digit_r[6:0], mem_r[rd_ptr_r]};
                     mask_r  <= {mask_r[6:0], 1'b1};
                  end else begin
                     // Queue drained: finish, leaving the last frame on the display.
                     state_r <= IDLE;
                     busy_r  <= 1'b0;
                     done_r  <= 1'b1;
                  end
               end else begin
                  cnt_r <= cnt_r + ONE_CNT;
               end
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign digit7 = digit_r[7];
   assign digit6 = digit_r[6];
   assign digit5 = digit_r[5];
   assign digit4 = digit_r[4];
   assign digit3 = digit_r[3];
   assign digit2 = digit_r[2];
   assign digit1 = digit_r[1];
   assign digit0 = digit_r[0];
   assign mask   = mask_r;
   assign busy   = busy_r;
   assign done   = done_r;
   assign level  = level_r;

endmodule

// File: tb/tb_ss_scroll_ctrl.sv
// Self-checking bench for ss_scroll_ctrl: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_ss_scroll_ctrl;

   localparam int DEPTH = 16;
   localparam int DIV   = 4;
   localparam int CW    = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_valid = 1'b0;
   logic [3:0] wr_data = 4'h0;
   logic       show = 1'b0;
   logic       wr_ready;
   logic [3:0] digit7, digit6, digit5, digit4, digit3, digit2, digit1, digit0;
   logic [7:0] mask;
   logic       busy;
   logic       done;
   logic [4:0] level;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en = 1'b0;

   ss_scroll_ctrl #(.DEPTH(DEPTH), .SCROLL_DIV(DIV), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
      .show(show),
      .digit7(digit7), .digit6(digit6), .digit5(digit5), .digit4(digit4),
      .digit3(digit3), .digit2(digit2), .digit1(digit1), .digit0(digit0),
      .mask(mask), .busy(busy), .done(done), .level(level)
   );

   always #5 clk = ~clk;

   // Reference model: a queue for the FIFO, a digit array and a shift count for the display.
   int       q[$];
   bit [3:0] m_dig[8];
   int       m_n = 0;
   bit       m_busy = 1'b0;
   bit       m_done = 1'b0;
   int       m_el = 0;
   bit       m_push;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         q.delete();
         for (int i = 0; i < 8; i++) m_dig[i] = 4'h0;
         m_n = 0; m_busy = 1'b0; m_done = 1'b0; m_el = 0;
      end else begin
         m_push = wr_valid && (q.size() < DEPTH);
         m_done = 1'b0;
         if (!m_busy) begin
            if (show && q.size() > 0) begin
               for (int i = 0; i < 8; i++) m_dig[i] = 4'h0;
               m_n = 0; m_busy = 1'b1; m_el = 0;
            end
         end else begin
            m_el++;
            if (m_el % DIV == 0) begin
               if (q.size() > 0) begin
                  for (int i = 7; i > 0; i--) m_dig[i] = m_dig[i-1];
                  m_dig[0] = 4'(q.pop_front());
                  m_n++;
               end else begin
                  m_busy = 1'b0;
                  m_done = 1'b1;
               end
            end
         end
         if (m_push) q.push_back(int'(wr_data));
      end
   end

   function automatic logic [31:0] exp_digits();
      logic [31:0] v = 32'h0;
      for (int i = 0; i < 8; i++) v = v | (32'(m_dig[i]) << (4 * i));
      return v;
   endfunction

   function automatic logic [31:0] exp_mask();
      if (m_n >= 8) return 32'hFF;
      return (32'h1 << m_n) - 32'h1;
   endfunction

   function automatic logic [31:0] dut_digits();
      return {digit7, digit6, digit5, digit4, digit3, digit2, digit1, digit0};
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_digits",   dut_digits(),   exp_digits());
         chk("model_mask",     32'(mask),      exp_mask());
         chk("model_busy",     32'(busy),      32'(m_busy));
         chk("model_done",     32'(done),      32'(m_done));
         chk("model_level",    32'(level),     32'(q.size()));
         chk("model_wr_ready", 32'(wr_ready),  32'(q.size() != DEPTH));
      end
   end

   task automatic tick_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push1(input logic [3:0] d);
      wr_valid = 1'b1; wr_data = d;
      @(negedge clk);
      wr_valid = 1'b0;
   endtask

   task automatic pulse_show();
      show = 1'b1;
      @(negedge clk);
      show = 1'b0;
   endtask

   task automatic wait_idle(input int max);
      int k = 0;
      while (busy && k < max) begin
         @(negedge clk);
         k++;
      end
      if (busy) begin
         n_checks++;
         n_errors++;
         $display("FAIL wait_idle: busy still %b after %0d cycles", busy, max);
      end
   endtask

   initial begin
      #1 rst = 1'b0;
      chk_en = 1'b1;
      #1;
      chk("reset_digits", dut_digits(), 32'h0);
      chk("reset_mask", 32'(mask), 32'h0);
      chk("reset_wr_ready", 32'(wr_ready), 32'h1);
      tick_n(2);
      rst = 1'b1;
      tick_n(1);

      // Three nibbles, ticks every 4 cycles, done on the empty tick.
      push1(4'h1); push1(4'h2); push1(4'h3);
      pulse_show();
      tick_n(4);
      chk("t1_digits_tick1", dut_digits(), 32'h0000_0001);
      chk("t1_mask_tick1", 32'(mask), 32'h01);
      tick_n(8);
      chk("t1_digits_tick3", dut_digits(), 32'h0000_0123);
      chk("t1_mask_tick3", 32'(mask), 32'h07);
      tick_n(3);
      chk("t1_no_early_done", 32'({busy, done}), 32'b10);
      tick_n(1);
      chk("t1_done_busy", 32'({busy, done}), 32'b01);
      chk("t1_held_digits", dut_digits(), 32'h0000_0123);
      tick_n(1);
      chk("t1_done_one_cycle", 32'(done), 32'h0);

      // Ten nibbles overflow the eight positions.
      for (int i = 0; i < 10; i++) push1(4'(i));
      pulse_show();
      wait_idle(200);
      chk("t2_digits", dut_digits(), 32'h2345_6789);
      chk("t2_mask", 32'(mask), 32'hFF);
      chk("t2_level", 32'(level), 32'h0);
      tick_n(1);

      // Fill the FIFO and try one extra push.
      for (int i = 0; i < 16; i++) push1(4'(15 - i));
      chk("t3_full_level", 32'(level), 32'd16);
      chk("t3_full_ready", 32'(wr_ready), 32'h0);
      push1(4'h7);
      chk("t3_reject_level", 32'(level), 32'd16);
      pulse_show();
      tick_n(3);
      chk("t3_still_full", 32'(wr_ready), 32'h0);
      tick_n(1);
      chk("t3_ready_after_pop", 32'(wr_ready), 32'h1);
      chk("t3_level_after_pop", 32'(level), 32'd15);
      wait_idle(200);
      chk("t3_digits", dut_digits(), 32'h7654_3210);

      // Show on an empty FIFO, then show while busy.
      pulse_show();
      chk("t4_empty_show_busy", 32'({busy, done}), 32'b00);
      chk("t4_empty_show_disp", dut_digits(), 32'h7654_3210);
      push1(4'h7); push1(4'h8);
      pulse_show();
      tick_n(1);
      pulse_show();
      tick_n(2);
      chk("t4_tick1_digits", dut_digits(), 32'h0000_0007);
      tick_n(4);
      chk("t4_tick2_digits", dut_digits(), 32'h0000_0078);
      wait_idle(100);

      // Append during scroll delays done by one tick period.
      push1(4'h5);
      pulse_show();
      tick_n(2);
      push1(4'hA);
      tick_n(8);
      chk("t5_no_done_yet", 32'({busy, done}), 32'b10);
      tick_n(1);
      chk("t5_done", 32'({busy, done}), 32'b01);
      chk("t5_digits", dut_digits(), 32'h0000_005A);
      chk("t5_mask", 32'(mask), 32'h03);

      // Asynchronous reset in the middle of a scroll.
      push1(4'h1); push1(4'h2); push1(4'h3);
      pulse_show();
      tick_n(5);
      #2 rst = 1'b0;
      #1;
      chk("t6_digits", dut_digits(), 32'h0);
      chk("t6_mask", 32'(mask), 32'h0);
      chk("t6_busy", 32'(busy), 32'h0);
      chk("t6_level", 32'(level), 32'h0);
      chk("t6_wr_ready", 32'(wr_ready), 32'h1);
      tick_n(2);
      rst = 1'b1;
      tick_n(2);
      pulse_show();
      chk("t6_show_after_reset", 32'(busy), 32'h0);
      push1(4'hC);
      pulse_show();
      wait_idle(100);
      chk("t6_fresh_digits", dut_digits(), 32'h0000_000C);
      chk("t6_fresh_mask", 32'(mask), 32'h01);

      // Randomized traffic checked by the model.
      for (int c = 0; c < 600; c++) begin
         wr_valid = ($urandom_range(0, 2) == 0);
         wr_data  = 4'($urandom_range(0, 15));
         show     = ($urandom_range(0, 15) == 0);
         @(negedge clk);
      end
      wr_valid = 1'b0;
      show = 1'b0;
      wait_idle(400);
      tick_n(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
